inst_queue: RTL

Dual-port instruction queue between fetch and the dual-issue stage. Fetch pushes up to two {pc, inst} entries per cycle. The issue stage sees the two oldest entries with per-entry valid flags and pops zero, one or two per cycle. The queue owns all pointer sequencing, backpressure and pipeline-flush clearing.

---
 rtl/inst_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-push / dual-pop instruction queue between fetch and dual issue
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       w_ena_1,
    input  logic [WIDTH-1:0]           w_data_1,
    input  logic                       w_ena_2,
    input  logic [WIDTH-1:0]           w_data_2,
    output logic                       w_ready,
    input  logic                       p_data_1,
    input  logic                       p_data_2,
    output logic [WIDTH-1:0]           r_data_1,
    output logic                       r_data_1_ok,
    output logic [WIDTH-1:0]           r_data_2,
    output logic                       r_data_2_ok,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;
    logic [CW-1:0]    cnt;

    logic [AW-1:0]    rp_inc1;
    logic [AW-1:0]    wp_inc1;
    logic [CW-1:0]    free;
    logic [1:0]       pw;
    logic [1:0]       pp_raw;
    logic [1:0]       pp;
    logic             push_ok;
    logic [1:0]       pw_acc;

    assign rp_inc1 = rp + AW'(1);
    assign wp_inc1 = wp + AW'(1);
    assign free    = CW'(DEPTH) - cnt;

    // A lone second-slot request has no older partner, so it is treated as nothing.
    always_comb begin
        pw      = 2'd0;
        pp_raw  = 2'd0;
        pp      = 2'd0;
        push_ok = 1'b0;
        pw_acc  = 2'd0;

        if (w_ena_1) begin
            pw = w_ena_2 ? 2'd2 : 2'd1;
        end
        if (p_data_1) begin
            pp_raw = p_data_2 ? 2'd2 : 2'd1;
        end

        if (CW'(pp_raw) > cnt) begin
            pp = cnt[1:0];
        end else begin
            pp = pp_raw;
        end

        // All-or-nothing push: a pair that does not fit is dropped whole.
        push_ok = (free >= CW'(pw));
        pw_acc  = push_ok ? pw : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            rp  <= rp + AW'(pp);
            wp  <= wp + AW'(pw_acc);
            cnt <= cnt + CW'(pw_acc) - CW'(pp);
        end
    end

    // Storage is never cleared; validity is carried entirely by cnt.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (pw_acc != 2'd0) begin
                mem[wp] <= w_data_1;
            end
            if (pw_acc == 2'd2) begin
                mem[wp_inc1] <= w_data_2;
            end
        end
    end

    assign r_data_1    = mem[rp];
    assign r_data_2    = mem[rp_inc1];
    assign r_data_1_ok = (cnt != '0);
    assign r_data_2_ok = (cnt >= CW'(2));
    assign count       = cnt;
    assign w_ready     = (free >= CW'(2));

endmodule
